// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared types and the forwarding-select helper for the pipeline controller
package pipeline_ctrl_pkg;
  typedef logic [4:0] reg_addr_t;
  typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10} fwd_sel_e;
  typedef enum logic [1:0] {BOOT, RUN, MD_BUSY} pctrl_state_e;
  // Memory stage wins over writeback since it holds the younger result.
  function automatic fwd_sel_e fwd_sel(input reg_addr_t rs, input reg_addr_t rd_mem, input logic we_mem,
                                       input reg_addr_t rd_wb, input logic we_wb);
    return (we_mem && rd_mem != '0 && rd_mem == rs) ? FWD_MEM :
           (we_wb && rd_wb != '0 && rd_wb == rs) ? FWD_WB : FWD_RF;
  endfunction
endpackage

// File: rtl/pipeline_ctrl_forward_unit.sv
// pipeline_ctrl_forward_unit: combinational operand forwarding selects for execute
module pipeline_ctrl_forward_unit
  import pipeline_ctrl_pkg::*;
(
  input  reg_addr_t rs1_ex,
  input  reg_addr_t rs2_ex,
  input  reg_addr_t rd_mem,
  input  reg_addr_t rd_wb,
  input  logic      reg_write_mem,
  input  logic      reg_write_wb,
  output fwd_sel_e  fwd_a,
  output fwd_sel_e  fwd_b
);
  assign fwd_a = fwd_sel(rs1_ex, rd_mem, reg_write_mem, rd_wb, reg_write_wb);
  assign fwd_b = fwd_sel(rs2_ex, rd_mem, reg_write_mem, rd_wb, reg_write_wb);
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: boot reset sequencing, hazard stall/flush, branch redirect and multi-cycle op freeze
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int BOOT_CYCLES = 4,
  parameter int MD_TIMEOUT  = 64,
  parameter int STALL_CNT_W = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [4:0]             rs1_dc_i,
  input  logic [4:0]             rs2_dc_i,
  input  logic [4:0]             rs1_ex_i,
  input  logic [4:0]             rs2_ex_i,
  input  logic [4:0]             rd_ex_i,
  input  logic [4:0]             rd_mem_i,
  input  logic [4:0]             rd_wb_i,
  input  logic                   reg_write_mem_i,
  input  logic                   reg_write_wb_i,
  input  logic                   load_ex_i,
  input  logic                   branch_taken_ex_i,
  input  logic                   md_start_ex_i,
  input  logic                   md_done_i,
  output logic                   pipe_rst_o,
  output logic                   pc_src_ft_o,
  output logic                   stall_ft_o,
  output logic                   stall_dc_o,
  output logic                   stall_ex_o,
  output logic                   flush_dc_o,
  output logic                   flush_ex_o,
  output logic                   flush_mem_o,
  output logic [1:0]             fwd_a_ex_o,
  output logic [1:0]             fwd_b_ex_o,
  output logic                   md_err_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);
  localparam int CNT_MAX = BOOT_CYCLES > MD_TIMEOUT ? BOOT_CYCLES : MD_TIMEOUT;
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] MD_LAST = CNT_W'(MD_TIMEOUT - 1);
  pctrl_state_e state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic lu, md_wait, run_br, run_lu, md_abort;
  fwd_sel_e fwd_a, fwd_b;

  pipeline_ctrl_forward_unit u_forward_unit (
    .rs1_ex        (rs1_ex_i),
    .rs2_ex        (rs2_ex_i),
    .rd_mem        (rd_mem_i),
    .rd_wb         (rd_wb_i),
    .reg_write_mem (reg_write_mem_i),
    .reg_write_wb  (reg_write_wb_i),
    .fwd_a         (fwd_a),
    .fwd_b         (fwd_b)
  );
  assign fwd_a_ex_o = fwd_a;
  assign fwd_b_ex_o = fwd_b;
  assign lu = load_ex_i && rd_ex_i != '0 && (rd_ex_i == rs1_dc_i || rd_ex_i == rs2_dc_i);

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state       <= BOOT;
      cnt         <= '0;
      pipe_rst_o  <= 1'b1;
      md_err_o    <= 1'b0;
      stall_cnt_o <= '0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      pipe_rst_o  <= state_nx == BOOT;
      md_err_o    <= md_err_o | md_abort;
      stall_cnt_o <= (stall_ft_o && !(&stall_cnt_o)) ? stall_cnt_o + STALL_CNT_W'(1) : stall_cnt_o;
    end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      BOOT: begin
        state_nx = cnt == BOOT_LAST ? RUN : BOOT;
        cnt_nx   = cnt == BOOT_LAST ? '0 : cnt + CNT_W'(1);
      end
      RUN: if (!branch_taken_ex_i && md_start_ex_i && !md_done_i) begin
        state_nx = MD_BUSY;
        cnt_nx   = CNT_W'(1);
      end
      MD_BUSY: begin
        state_nx = (md_done_i || cnt == MD_LAST) ? RUN : MD_BUSY;
        cnt_nx   = (md_done_i || cnt == MD_LAST) ? '0 : cnt + CNT_W'(1);
      end
      default: state_nx = BOOT;
    endcase
  end

  // BOOT drives no control at all; MD_BUSY ignores branch and load-use.
  always_comb begin
    run_br      = state == RUN && branch_taken_ex_i;
    md_wait     = (state == RUN && !branch_taken_ex_i && md_start_ex_i && !md_done_i) ||
                  (state == MD_BUSY && !md_done_i && cnt != MD_LAST);
    run_lu      = state == RUN && !branch_taken_ex_i && !(md_start_ex_i && !md_done_i) && lu;
    md_abort    = state == MD_BUSY && !md_done_i && cnt == MD_LAST;
    pc_src_ft_o = run_br;
    stall_ft_o  = md_wait || run_lu;
    stall_dc_o  = md_wait || run_lu;
    stall_ex_o  = md_wait;
    flush_dc_o  = run_br;
    flush_ex_o  = run_br || run_lu || md_abort;
    flush_mem_o = md_wait;
  end
endmodule
